// File: rtl/seg7_scan_ctrl_if.sv
// Wrapper-side bus of the 7-segment scan controller: display data in, scan outputs back.
interface seg7_scan_ctrl_if #(
  parameter int unsigned AN_NUM = 8
);
  logic                  enable_i;
  logic [4*AN_NUM-1:0]   num_i;
  logic [AN_NUM-1:0]     digit_en_i;
  logic                  update_i;
  logic                  update_done_o;
  logic                  frame_o;
  logic [AN_NUM-1:0]     an_o;
  logic [6:0]            cath_o;

  // Register wrapper / bench side
  modport master (
    output enable_i, num_i, digit_en_i, update_i,
    input  update_done_o, frame_o, an_o, cath_o
  );

  // Scan controller side
  modport slave (
    input  enable_i, num_i, digit_en_i, update_i,
    output update_done_o, frame_o, an_o, cath_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double buffering.
module seg7_scan_ctrl #(
  parameter int unsigned AN_NUM       = 8,
  parameter int unsigned DIGIT_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic             pclk_i,
  input logic             presetn_i,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned MaxCycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned IdxW      = (AN_NUM > 1) ? $clog2(AN_NUM) : 1;
  localparam int unsigned NumW      = 4 * AN_NUM;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(AN_NUM - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StDrive = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NumW-1:0]   stg_num_q, stg_num_d;
  logic [AN_NUM-1:0] stg_mask_q, stg_mask_d;
  logic              pend_q, pend_d;
  logic [NumW-1:0]   sh_num_q, sh_num_d;
  logic [AN_NUM-1:0] sh_mask_q, sh_mask_d;
  logic [AN_NUM-1:0] an_q, an_d;
  logic [6:0]        cath_q, cath_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;
  logic [3:0]        nib;

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] seg;
    case (h)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Next-state: staging capture, scan sequencing and shadow reload at frame boundaries
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    stg_num_d  = stg_num_q;
    stg_mask_d = stg_mask_q;
    pend_d     = pend_q;
    sh_num_d   = sh_num_q;
    sh_mask_d  = sh_mask_q;
    frame_d    = 1'b0;
    done_d     = 1'b0;

    // Latest request wins; overwrites any earlier staged value
    if (bus.update_i) begin
      stg_num_d  = bus.num_i;
      stg_mask_d = bus.digit_en_i;
      pend_d     = 1'b1;
    end

    if (!bus.enable_i && state_q != StIdle) begin
      // Pending update survives a disable and is applied from idle
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          idx_d = '0;
          cnt_d = '0;
          if (pend_q) begin
            sh_num_d  = stg_num_q;
            sh_mask_d = stg_mask_q;
            done_d    = 1'b1;
            pend_d    = bus.update_i;
          end
          if (bus.enable_i) state_d = StBlank;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (cnt_q == DigitLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d   = '0;
              frame_d = 1'b1;
              // A request landing on the frame-end cycle bypasses staging
              if (bus.update_i) begin
                sh_num_d  = bus.num_i;
                sh_mask_d = bus.digit_en_i;
                done_d    = 1'b1;
                pend_d    = 1'b0;
              end else if (pend_q) begin
                sh_num_d  = stg_num_q;
                sh_mask_d = stg_mask_q;
                done_d    = 1'b1;
                pend_d    = 1'b0;
              end
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from next state so anodes/cathodes are registered
  always_comb begin
    an_d   = '1;
    cath_d = 7'h7F;
    nib    = '0;
    for (int k = 0; k < AN_NUM; k++) begin
      if (idx_d == IdxW'(k)) nib = sh_num_d[4*k +: 4];
    end
    if (state_d == StDrive && sh_mask_d[idx_d]) begin
      an_d[idx_d] = 1'b0;
      cath_d      = decode(nib);
    end
  end

  // State and output registers
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      stg_num_q  <= '0;
      stg_mask_q <= '0;
      pend_q     <= 1'b0;
      sh_num_q   <= '0;
      sh_mask_q  <= '0;
      an_q       <= '1;
      cath_q     <= 7'h7F;
      frame_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stg_num_q  <= stg_num_d;
      stg_mask_q <= stg_mask_d;
      pend_q     <= pend_d;
      sh_num_q   <= sh_num_d;
      sh_mask_q  <= sh_mask_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
    end
  end

  assign bus.an_o          = an_q;
  assign bus.cath_o        = cath_q;
  assign bus.frame_o       = frame_q;
  assign bus.update_done_o = done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2 (48-cycle frame).
module tb_seg7_scan_ctrl;

  localparam int Slot  = 6;
  localparam int Frame = 48;

  logic clk = 1'b0;
  logic presetn = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.AN_NUM(8)) bus ();

  seg7_scan_ctrl #(
    .AN_NUM      (8),
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .pclk_i   (clk),
    .presetn_i(presetn),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] cath;
    logic       frame;
    logic       done;
    string      tag;
  } entry_t;

  entry_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  // Bench-side view of what should be on the display
  int         pos = 0;
  bit         run_q = 1'b0;
  bit [31:0]  m_num = '0;
  bit [7:0]   m_mask = '0;
  string      phase = "reset";

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic entry_t model(input int p, input bit fr, input bit dn, input bit on);
    entry_t e;
    int k;
    int s;
    k       = p / Slot;
    s       = p % Slot;
    e.an    = 8'hFF;
    e.cath  = 7'h7F;
    e.frame = fr;
    e.done  = dn;
    e.tag   = $sformatf("%s@%0d", phase, p);
    if (on && s >= 2 && m_mask[k]) begin
      e.an[k] = 1'b0;
      e.cath  = dec(m_num[4*k +: 4]);
    end
    return e;
  endfunction

  // One clock: drive inputs, then record what the outputs must show after the edge
  task automatic adv(input bit en, input bit upd, input bit [31:0] n, input bit [7:0] m,
                     input bit dn);
    entry_t e;
    bus.enable_i   = en;
    bus.update_i   = upd;
    bus.num_i      = n;
    bus.digit_en_i = m;
    @(posedge clk);
    if (!en) begin
      run_q = 1'b0;
      pos   = 0;
      e     = model(0, 1'b0, dn, 1'b0);
    end else if (!run_q) begin
      run_q = 1'b1;
      pos   = 0;
      e     = model(0, 1'b0, dn, 1'b1);
    end else begin
      pos = (pos + 1) % Frame;
      e   = model(pos, pos == 0, dn, 1'b1);
    end
    exp_q.push_back(e);
    #1;
    bus.update_i = 1'b0;
  endtask

  task automatic idle_run(input int cycles);
    for (int i = 0; i < cycles; i++) adv(1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge
  always @(negedge clk) begin
    entry_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (bus.an_o !== e.an || bus.cath_o !== e.cath || bus.frame_o !== e.frame ||
          bus.update_done_o !== e.done) begin
        n_err++;
        $display("FAIL %s: got an=%h cath=%h frame=%b done=%b, want an=%h cath=%h frame=%b done=%b",
                 e.tag, bus.an_o, bus.cath_o, bus.frame_o, bus.update_done_o,
                 e.an, e.cath, e.frame, e.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable_i   = 1'b0;
    bus.update_i   = 1'b0;
    bus.num_i      = '0;
    bus.digit_en_i = '0;
    repeat (2) @(posedge clk);
    #1 presetn = 1'b1;

    // Disabled with nothing staged: display stays dark, no frame pulses
    phase = "idle";
    repeat (8) adv(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);

    // Stage in idle, then enable: shadow loads and update_done pulses with the first blank
    phase = "load";
    adv(1'b0, 1'b1, 32'h7654_3210, 8'hFF, 1'b0);
    m_num  = 32'h7654_3210;
    m_mask = 8'hFF;
    adv(1'b1, 1'b0, 32'h0, 8'h00, 1'b1);
    phase = "scan";
    idle_run(47 + Frame);

    // Update on the frame-end cycle goes straight to shadow: mask 05
    phase  = "mask05";
    m_mask = 8'h05;
    adv(1'b1, 1'b1, 32'h7654_3210, 8'h05, 1'b1);
    idle_run(47);

    // Mid-frame update held until the next frame
    phase = "midupd";
    idle_run(10);
    adv(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b0);
    idle_run(37);
    m_num  = 32'hFFFF_FFFF;
    m_mask = 8'hFF;
    adv(1'b1, 1'b0, 32'h0, 8'h00, 1'b1);
    idle_run(47);

    // Two mid-frame updates then one on frame end: last wins, single done pulse
    phase = "latest";
    idle_run(6);
    adv(1'b1, 1'b1, 32'h1111_1111, 8'hFF, 1'b0);
    idle_run(9);
    adv(1'b1, 1'b1, 32'h2222_2222, 8'h0F, 1'b0);
    idle_run(31);
    m_num  = 32'h89AB_CDEF;
    m_mask = 8'hA5;
    adv(1'b1, 1'b1, 32'h89AB_CDEF, 8'hA5, 1'b1);
    idle_run(47);
    idle_run(34);

    // Drop enable during digit 5, then restart from digit 0
    phase = "disable";
    repeat (4) adv(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    phase = "restart";
    idle_run(34);

    // Asynchronous reset during digit 5 drive: dark before the next clock edge
    phase = "areset";
    bus.enable_i = 1'b1;
    @(posedge clk);
    begin
      entry_t e;
      e = model(0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
    end
    #1 presetn = 1'b0;
    run_q = 1'b0;
    pos   = 0;
    @(posedge clk);
    #1 presetn = 1'b1;

    // Shadow cleared by reset: a full frame with nothing lit
    phase  = "postrst";
    m_num  = '0;
    m_mask = '0;
    idle_run(Frame + 1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
